// File: rtl/uart_rx_mv_pkg.sv
// Shared types and helpers for the majority-vote UART receiver.
// Parity helper is also used by the transmitter's parity option.
package uart_rx_mv_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int unsigned MAX_DATA = 9;

  // Returns the parity bit a transmitter appends: even parity when odd=0.
  function automatic logic parity_calc(input logic [MAX_DATA-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_mv_sampler.sv
// Line front end: 2-flop synchroniser, stick-driven sample history, 3-way vote, fall detect.
// Vote is combinational over the two stored samples plus the one taken on the current stick.
module uart_rx_mv_sampler (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stick,
  input  logic i_rx_serial,
  output logic o_vote,
  output logic o_fall
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q,  prev_d;
  logic [1:0] hist_q,  hist_d;
  logic [2:0] window;

  always_comb begin
    sync1_d = i_rx_serial;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    hist_d  = hist_q;
    if (i_stick) begin
      hist_d = {hist_q[0], sync2_q};
    end
    // window = samples at ticks n-2, n-1, n when consumed on stick n
    window = {hist_q, sync2_q};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      hist_q  <= 2'b11;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      hist_q  <= hist_d;
    end
  end

  assign o_vote = (window[2] & window[1]) | (window[2] & window[0]) | (window[1] & window[0]);
  assign o_fall = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_rx_mv.sv
// Majority-vote UART receiver: start/data/parity/stop FSM driven by oversample sticks.
// Delivery one clk after the stop-bit vote; a full FIFO turns a good frame into an overrun pulse.
module uart_rx_mv #(
  parameter int SIZE_DATA   = 8,
  parameter int OVER_SAMPLE = 16,
  parameter int MID_SAMPLE  = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stick,
  input  logic                 i_rx_en,
  input  logic                 i_fifo_full,
  input  logic                 i_rx_serial,
  output logic [SIZE_DATA-1:0] o_rx_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);
  import uart_rx_mv_pkg::*;

  localparam int TW = $clog2(OVER_SAMPLE);
  localparam int BW = $clog2(SIZE_DATA);
  localparam logic [TW-1:0] TICK_VOTE = TW'(MID_SAMPLE + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVER_SAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SIZE_DATA - 1);

  logic vote, fall, centre;

  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [SIZE_DATA-1:0] data_q, data_d;
  logic [SIZE_DATA-1:0] rx_data_q, rx_data_d;
  logic                 perr_q, perr_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic [MAX_DATA-1:0]  data_ext;

  uart_rx_mv_sampler u_sampler (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_stick     (i_stick),
    .i_rx_serial (i_rx_serial),
    .o_vote      (vote),
    .o_fall      (fall)
  );

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    data_d     = data_q;
    rx_data_d  = rx_data_q;
    perr_d     = perr_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    perr_out_d = 1'b0;
    ovr_d      = 1'b0;
    centre     = i_stick && (tick_q == TICK_VOTE);
    data_ext   = '0;
    data_ext[SIZE_DATA-1:0] = data_q;

    if (i_stick) begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      RX_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        perr_d = 1'b0;
        if (i_rx_en && fall) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (centre) begin
          state_d = vote ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (centre) begin
          data_d = {vote, data_q[SIZE_DATA-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (centre) begin
          perr_d  = parity_calc(data_ext, 1'(PARITY_ODD)) != vote;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // Leave at the stop centre so the next start edge resynchronises the bit clock.
        if (centre) begin
          state_d = RX_IDLE;
          if (!vote) begin
            ferr_d = 1'b1;
          end else if (perr_q) begin
            perr_out_d = 1'b1;
          end else if (i_fifo_full) begin
            ovr_d = 1'b1;
          end else begin
            rx_data_d = data_q;
            done_d    = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase

    busy_d = (state_d != RX_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= RX_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      rx_data_q  <= '0;
      perr_q     <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      rx_data_q  <= rx_data_d;
      perr_q     <= perr_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      perr_out_q <= perr_out_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
    end
  end

  assign o_rx_data    = rx_data_q;
  assign o_rx_done    = done_q;
  assign o_frame_err  = ferr_q;
  assign o_parity_err = perr_out_q;
  assign o_overrun    = ovr_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_mv.sv
// Bench for uart_rx_mv: an 8N1 receiver and an 8E1 receiver fed by a stick-aligned bit-level transmitter.
module tb_uart_rx_mv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, stick, rx_en, fifo_full, ser0, ser1;
  logic [7:0] data0, data1;
  logic       done0, ferr0, perr0, ovr0, busy0;
  logic       done1, ferr1, perr1, ovr1, busy1;

  uart_rx_mv #(.SIZE_DATA(8), .OVER_SAMPLE(16), .MID_SAMPLE(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_stick(stick), .i_rx_en(rx_en), .i_fifo_full(fifo_full),
    .i_rx_serial(ser0), .o_rx_data(data0), .o_rx_done(done0), .o_frame_err(ferr0),
    .o_parity_err(perr0), .o_overrun(ovr0), .o_busy(busy0)
  );

  uart_rx_mv #(.SIZE_DATA(8), .OVER_SAMPLE(16), .MID_SAMPLE(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .i_clk(clk), .i_rst(rst), .i_stick(stick), .i_rx_en(rx_en), .i_fifo_full(fifo_full),
    .i_rx_serial(ser1), .o_rx_data(data1), .o_rx_done(done1), .o_frame_err(ferr1),
    .o_parity_err(perr1), .o_overrun(ovr1), .o_busy(busy1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: per instance, the last delivered word and the pulse due after a stop-bit centre.
  logic [7:0] exp_data  [2];
  logic [3:0] exp_pulse [2];   // {done, frame_err, parity_err, overrun}
  bit         exp_due   [2];
  bit         cmp_on = 1'b0;
  int         n_done [2], n_ferr [2], n_perr [2], n_ovr [2];

  bit stick_run = 1'b1;
  int stick_cnt = 0;
  bit spike_on = 1'b0;
  int rst_bit = -1, pause_bit = -1, rxen_drop_bit = -1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  initial begin
    stick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stick_run) begin
        stick = (stick_cnt == 3);
        stick_cnt = (stick_cnt + 1) % 4;
      end else begin
        stick = 1'b0;
      end
    end
  end

  // Per-cycle compare of pulses and held word against the model.
  initial begin
    logic [3:0] act;
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        for (int k = 0; k < 2; k++) begin
          act = (k == 0) ? {done0, ferr0, perr0, ovr0} : {done1, ferr1, perr1, ovr1};
          check((k == 0) ? "pulses_8n1" : "pulses_8e1", act, exp_due[k] ? exp_pulse[k] : 4'b0000);
          check((k == 0) ? "rx_data_8n1" : "rx_data_8e1", (k == 0) ? data0 : data1, exp_data[k]);
          exp_due[k] = 1'b0;
        end
        n_done[0] += done0; n_ferr[0] += ferr0; n_perr[0] += perr0; n_ovr[0] += ovr0;
        n_done[1] += done1; n_ferr[1] += ferr1; n_perr[1] += perr1; n_ovr[1] += ovr1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  task automatic wait_stick();
    do @(posedge clk); while (stick !== 1'b1);
  endtask

  task automatic drive(input int k, input logic v);
    if (k == 0) ser0 = v;
    else        ser1 = v;
  endtask

  task automatic idle(input int n);
    repeat (n) wait_stick();
  endtask

  // Expected outcome of a frame from its bits alone.
  task automatic predict(input int k, input logic [7:0] d, input logic stop_bit, input logic par_bit);
    exp_due[k] = 1'b1;
    if (!stop_bit)
      exp_pulse[k] = 4'b0100;
    else if (k == 1 && ((($countones(d) + int'(par_bit)) % 2) != 0))
      exp_pulse[k] = 4'b0010;
    else if (fifo_full)
      exp_pulse[k] = 4'b0001;
    else begin
      exp_pulse[k] = 4'b1000;
      exp_data[k]  = d;
    end
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic stop_bit, input logic par_bit,
                      input bit accept);
    logic [10:0] bits;
    int          nbits;
    logic        v;
    bits = '0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (k == 1) begin bits[9] = par_bit; bits[10] = stop_bit; nbits = 11; end
    else        begin bits[9] = stop_bit; nbits = 10; end
    wait_stick();
    for (int b = 0; b < nbits; b++) begin
      for (int s = 0; s < 16; s++) begin
        v = bits[b];
        if (spike_on && s == 8) v = ~v;
        #2;
        drive(k, v);
        wait_stick();
        if (accept && b == nbits - 1 && s == 9) predict(k, d, stop_bit, par_bit);
        if (b == rxen_drop_bit && s == 0) rx_en = 1'b0;
        if (b == pause_bit && s == 5) begin
          stick_run = 1'b0;
          repeat (60) @(posedge clk);
          stick_run = 1'b1;
        end
        if (b == rst_bit && s == 3) begin
          #2;
          check("busy_mid_frame", busy0, 1'b1);
          rst = 1'b1;
          ser0 = 1'b1;
          @(posedge clk);
          exp_data[0] = '0; exp_data[1] = '0;
          exp_due[0] = 1'b0; exp_due[1] = 1'b0;
          @(negedge clk);
          check("reset_busy", busy0, 1'b0);
          check("reset_outputs", {data0, done0, ferr0, perr0, ovr0}, 0);
          rst = 1'b0;
          return;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; rx_en = 1'b1; fifo_full = 1'b0; ser0 = 1'b1; ser1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_data[k] = '0; exp_pulse[k] = '0; exp_due[k] = 1'b0;
      n_done[k] = 0; n_ferr[k] = 0; n_perr[k] = 0; n_ovr[k] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state_8n1", {data0, done0, ferr0, perr0, ovr0, busy0}, 0);
    check("reset_state_8e1", {data1, done1, ferr1, perr1, ovr1, busy1}, 0);
    rst = 1'b0;
    cmp_on = 1'b1;
    idle(20);

    // Plain 8N1 frame
    send(0, 8'h29, 1'b1, 1'b0, 1'b1);
    idle(8);
    check("word_29", data0, 8'h29);
    check("done_count_after_29", n_done[0], 1);

    // Short low glitch in IDLE: START is entered, then abandoned
    wait_stick(); #2; ser0 = 1'b0;
    wait_stick(); wait_stick(); #2;
    check("glitch_enters_start", busy0, 1'b1);
    wait_stick(); #2; ser0 = 1'b1;
    idle(32); #2;
    check("glitch_back_idle", busy0, 1'b0);

    // Stop bit forced low, then a long break
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    idle(16); #2;
    check("break_stays_idle", busy0, 1'b0);
    idle(20 * 16 - 16);
    #2; ser0 = 1'b1;
    idle(32);
    check("ferr_keeps_word", data0, 8'h29);
    check("ferr_count", n_ferr[0], 1);
    send(0, 8'h3C, 1'b1, 1'b0, 1'b1);
    idle(8);
    check("word_3c_after_break", data0, 8'h3C);

    // Even parity: 8'h07 has three ones, so the correct parity bit is 1
    send(1, 8'h07, 1'b1, 1'b0, 1'b1);
    idle(8);
    check("parity_err_count", n_perr[1], 1);
    check("parity_err_no_word", data1, 8'h00);
    send(1, 8'h07, 1'b1, 1'b1, 1'b1);
    idle(8);
    check("word_07_parity_ok", data1, 8'h07);

    // FIFO full turns a good frame into an overrun
    fifo_full = 1'b1;
    send(0, 8'h55, 1'b1, 1'b0, 1'b1);
    idle(8);
    fifo_full = 1'b0;
    check("overrun_count", n_ovr[0], 1);
    check("overrun_keeps_word", data0, 8'h3C);
    send(0, 8'h56, 1'b1, 1'b0, 1'b1);
    idle(8);
    check("word_56", data0, 8'h56);

    // Enable dropped mid-frame completes; a frame with enable low is ignored
    rxen_drop_bit = 3;
    send(0, 8'h9A, 1'b1, 1'b0, 1'b1);
    rxen_drop_bit = -1;
    idle(8);
    check("word_9a_en_dropped", data0, 8'h9A);
    send(0, 8'h12, 1'b1, 1'b0, 1'b0);
    idle(8); #2;
    check("disabled_not_busy", busy0, 1'b0);
    check("disabled_keeps_word", data0, 8'h9A);
    rx_en = 1'b1;
    idle(8);

    // Sticks paused mid-frame
    pause_bit = 4;
    send(0, 8'hC3, 1'b1, 1'b0, 1'b1);
    pause_bit = -1;
    idle(8);
    check("word_c3_paused", data0, 8'hC3);

    // Reset during data bit 4, then recovery
    rst_bit = 5;
    send(0, 8'h6B, 1'b1, 1'b0, 1'b1);
    rst_bit = -1;
    idle(32);
    send(0, 8'hFF, 1'b1, 1'b0, 1'b1);
    idle(8);
    check("word_ff_after_reset", data0, 8'hFF);

    // One-stick spikes at every bit centre are outvoted
    spike_on = 1'b1;
    send(0, 8'h29, 1'b1, 1'b0, 1'b1);
    spike_on = 1'b0;
    idle(8);
    check("word_29_spiked", data0, 8'h29);

    check("total_done_8n1", n_done[0], 7);
    check("total_done_8e1", n_done[1], 1);
    check("total_err_8n1", n_ferr[0] + n_perr[0] + n_ovr[0], 2);
    check("total_err_8e1", n_ferr[1] + n_ovr[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
